// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: FSM states, RV32I
// opcode and funct3 constants, and the ALU operation codes that the
// datapath ALU also decodes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    // Supported major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Branch funct3 codes
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // Arithmetic funct3 codes (shared by R-type and I-type)
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    // True for the opcodes that need a data-memory access
    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OP_LOAD) || (opcode == OP_STORE);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational instruction decoder: maps opcode/funct3/funct7[5] to the
// ALU operation, the immediate-operand select and a legality flag.
// Illegal encodings yield ALU_AND with no immediate so the control unit
// drives all-zero ALU controls for them.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_ctrl,
    output logic       alu_src,
    output logic       legal
);

    logic [3:0] arith_code;
    logic       arith_ok;

    // Arithmetic op from funct3; funct7[5] only matters for SUB (R-type) and SRA/SRAI
    always_comb begin
        arith_code = ALU_AND;
        arith_ok   = 1'b1;
        case (funct3)
            F3_ADD:  arith_code = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
            F3_SLL:  arith_code = ALU_SLL;
            F3_SLT:  arith_code = ALU_SLT;
            F3_XOR:  arith_code = ALU_XOR;
            F3_SR:   arith_code = funct7_5 ? ALU_SRA : ALU_SRL;
            F3_OR:   arith_code = ALU_OR;
            F3_AND:  arith_code = ALU_AND;
            default: arith_ok   = 1'b0;
        endcase
    end

    // Opcode class selects between arithmetic decode, address add and compare subtract
    always_comb begin
        alu_ctrl = ALU_AND;
        alu_src  = 1'b0;
        legal    = 1'b0;
        case (opcode)
            OP_R: begin
                legal    = arith_ok;
                alu_ctrl = arith_ok ? arith_code : ALU_AND;
            end
            OP_I: begin
                legal    = arith_ok;
                alu_ctrl = arith_ok ? arith_code : ALU_AND;
                alu_src  = arith_ok;
            end
            OP_LOAD, OP_STORE: begin
                legal    = 1'b1;
                alu_ctrl = ALU_ADD;
                alu_src  = 1'b1;
            end
            OP_BRANCH: begin
                if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
                    legal    = 1'b1;
                    alu_ctrl = ALU_SUB;
                end
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: steps each instruction through IF/ID/EX/MEM/WB,
// waits on the data-memory handshake with a timeout, and counts retired
// instructions. All outputs are registered, computed from the next state.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        PCSrc,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic [3:0]  ALUCtrl,
    output logic        loadPC,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        illegal_instr,
    output logic        bus_error,
    output logic [31:0] retired
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_load, is_store, is_branch, writes_rd, is_mem;
    logic [3:0] dec_alu_ctrl;
    logic       dec_alu_src, dec_legal;
    logic       unused_instr_bits;

    state_t            state_q, state_d;
    logic              zero_q, zero_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       retired_q, retired_d;
    logic              mem_err;

    logic       pc_src_q, pc_src_d;
    logic       alu_src_q, alu_src_d;
    logic       reg_write_q, reg_write_d;
    logic       mem_to_reg_q, mem_to_reg_d;
    logic [3:0] alu_ctrl_q, alu_ctrl_d;
    logic       load_pc_q, load_pc_d;
    logic       mem_read_q, mem_read_d;
    logic       mem_write_q, mem_write_d;
    logic       illegal_q, illegal_d;
    logic       bus_error_q, bus_error_d;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign is_load           = (opcode == OP_LOAD);
    assign is_store          = (opcode == OP_STORE);
    assign is_branch         = (opcode == OP_BRANCH);
    assign is_mem            = is_mem_op(opcode);
    assign writes_rd         = (opcode == OP_R) || (opcode == OP_I) || is_load;
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7_5 (instr[30]),
        .alu_ctrl (dec_alu_ctrl),
        .alu_src  (dec_alu_src),
        .legal    (dec_legal)
    );

    // Next-state logic: sequencing, Zero capture, MEM timeout and retire count
    always_comb begin
        state_d   = state_q;
        zero_d    = zero_q;
        cnt_d     = cnt_q;
        retired_d = retired_q;
        mem_err   = 1'b0;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: state_d = dec_legal ? S_EX : S_WB;
            S_EX: begin
                zero_d  = Zero;
                cnt_d   = '0;
                state_d = is_mem ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = S_WB;
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d = S_WB;
                    mem_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                state_d   = S_IF;
                retired_d = retired_q + 32'd1;
            end
            default: state_d = S_IF;
        endcase
    end

    // Output values for the state being entered, so registered outputs line up with it
    always_comb begin
        pc_src_d     = 1'b0;
        alu_src_d    = 1'b0;
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        alu_ctrl_d   = ALU_AND;
        load_pc_d    = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        illegal_d    = 1'b0;
        bus_error_d  = 1'b0;
        if (state_d == S_EX || state_d == S_MEM || state_d == S_WB) begin
            alu_ctrl_d = dec_alu_ctrl;
            alu_src_d  = dec_alu_src;
        end
        if (state_d == S_MEM) begin
            mem_read_d  = is_load;
            mem_write_d = is_store;
        end
        if (state_d == S_WB) begin
            load_pc_d    = 1'b1;
            reg_write_d  = writes_rd && dec_legal && !mem_err;
            mem_to_reg_d = is_load;
            illegal_d    = (state_q == S_ID) && !dec_legal;
            bus_error_d  = mem_err;
            if (is_branch && dec_legal) begin
                pc_src_d = (funct3 == F3_BEQ) ? zero_d : !zero_d;
            end
        end
    end

    // FSM and registered outputs; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IF;
            zero_q       <= 1'b0;
            cnt_q        <= '0;
            retired_q    <= '0;
            pc_src_q     <= 1'b0;
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_ctrl_q   <= ALU_AND;
            load_pc_q    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            illegal_q    <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            zero_q       <= zero_d;
            cnt_q        <= cnt_d;
            retired_q    <= retired_d;
            pc_src_q     <= pc_src_d;
            alu_src_q    <= alu_src_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            alu_ctrl_q   <= alu_ctrl_d;
            load_pc_q    <= load_pc_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            illegal_q    <= illegal_d;
            bus_error_q  <= bus_error_d;
        end
    end

    assign PCSrc         = pc_src_q;
    assign ALUSrc        = alu_src_q;
    assign RegWrite      = reg_write_q;
    assign MemToReg      = mem_to_reg_q;
    assign ALUCtrl       = alu_ctrl_q;
    assign loadPC        = load_pc_q;
    assign MemRead       = mem_read_q;
    assign MemWrite      = mem_write_q;
    assign illegal_instr = illegal_q;
    assign bus_error     = bus_error_q;
    assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed instructions, a per-instruction
// expected-trace model, and a negedge compare process.
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        Zero;
    logic        mem_ready;
    logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC;
    logic        MemRead, MemWrite, illegal_instr, bus_error;
    logic [3:0]  ALUCtrl;
    logic [31:0] retired;

    multicycle_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .Zero          (Zero),
        .mem_ready     (mem_ready),
        .PCSrc         (PCSrc),
        .ALUSrc        (ALUSrc),
        .RegWrite      (RegWrite),
        .MemToReg      (MemToReg),
        .ALUCtrl       (ALUCtrl),
        .loadPC        (loadPC),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .illegal_instr (illegal_instr),
        .bus_error     (bus_error),
        .retired       (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pcSrc;
        logic        aluSrc;
        logic        regWrite;
        logic        memToReg;
        logic [3:0]  aluCtrl;
        logic        loadPc;
        logic        memRead;
        logic        memWrite;
        logic        illegal;
        logic        busError;
        logic [31:0] retired;
    } outVec_t;

    // ALU code table indexed by {funct7[5], funct3}; -1 marks an unsupported funct3
    int arithTab [16] = '{2, 9, 7, -1, 13, 8, 1, 0,
                          6, 9, 7, -1, 13, 10, 1, 0};

    outVec_t expQ[$];
    string   nameQ[$];
    outVec_t expVec;
    string   expName;
    int      checks = 0;
    int      errors = 0;
    int      retiredModel = 0;
    int      nCycles;

    function automatic outVec_t actualVec();
        outVec_t a;
        a = '{PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC,
              MemRead, MemWrite, illegal_instr, bus_error, retired};
        return a;
    endfunction

    // Instruction-level model of the ALU controls
    function automatic void aluModel(input logic [31:0] ins, output bit legal,
                                     output logic [3:0] code, output bit src);
        logic [6:0] op;
        logic [2:0] f3;
        int idx;
        op = ins[6:0];
        f3 = ins[14:12];
        legal = 1'b0;
        code  = 4'd0;
        src   = 1'b0;
        if (op == 7'h33 || op == 7'h13) begin
            idx = (op == 7'h33 || f3 == 3'd5) ? {28'd0, ins[30], f3} : {29'd0, f3};
            if (arithTab[idx] >= 0) begin
                legal = 1'b1;
                code  = 4'(arithTab[idx]);
                src   = (op == 7'h13);
            end
        end else if (op == 7'h03 || op == 7'h23) begin
            legal = 1'b1;
            code  = 4'd2;
            src   = 1'b1;
        end else if (op == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) begin
            legal = 1'b1;
            code  = 4'd6;
        end
    endfunction

    // Push the cycle-by-cycle expected outputs of one instruction; returns its length
    function automatic int buildTrace(input string nm, input logic [31:0] ins, input bit z,
                                      input int w, input bit never);
        outVec_t v;
        bit legal, src, isLoad, isStore, isBranch, writes, err;
        logic [3:0] code;
        int memCycles, n;
        aluModel(ins, legal, code, src);
        isLoad   = (ins[6:0] == 7'h03);
        isStore  = (ins[6:0] == 7'h23);
        isBranch = (ins[6:0] == 7'h63);
        writes   = (ins[6:0] == 7'h33) || (ins[6:0] == 7'h13) || isLoad;
        err      = (isLoad || isStore) && (never || w > TIMEOUT);
        memCycles = 0;
        if (isLoad || isStore) memCycles = err ? TIMEOUT + 1 : w + 1;
        n = 0;
        v = '0;
        v.retired = 32'(retiredModel);
        repeat (2) begin
            expQ.push_back(v); nameQ.push_back(nm); n++;
        end
        if (legal) begin
            v.aluCtrl = code;
            v.aluSrc  = src;
            expQ.push_back(v); nameQ.push_back(nm); n++;
            v.memRead  = isLoad;
            v.memWrite = isStore;
            for (int i = 0; i < memCycles; i++) begin
                expQ.push_back(v); nameQ.push_back(nm); n++;
            end
            v.memRead  = 1'b0;
            v.memWrite = 1'b0;
        end
        v.loadPc   = 1'b1;
        v.regWrite = writes && legal && !err;
        v.memToReg = isLoad;
        v.pcSrc    = isBranch && legal && ((ins[14:12] == 3'd0) ? z : !z);
        v.illegal  = !legal;
        v.busError = err;
        expQ.push_back(v); nameQ.push_back(nm); n++;
        retiredModel++;
        return n;
    endfunction

    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called just after the edge that enters IF; drives one instruction to completion
    task automatic applyStimulus(input string nm, input logic [31:0] ins, input bit z,
                                 input int w, input bit never, output int n);
        instr = ins;
        Zero  = z;
        n = buildTrace(nm, ins, z, w, never);
        for (int c = 1; c <= n; c++) begin
            mem_ready = !never && (c >= 4 + w);
            @(posedge clk);
            #1;
        end
    endtask

    // Compare every cycle that has a predicted output vector
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            expVec  = expQ.pop_front();
            expName = nameQ.pop_front();
            checkOutput(expName, 64'(actualVec()), 64'(expVec));
        end
    end

    initial begin
        bit mLegal, mSrc;
        logic [3:0] mCode;

        rst = 1'b0; instr = 32'h0; Zero = 1'b0; mem_ready = 1'b0;
        #2;
        checkOutput("reset_outputs", 64'(actualVec()), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        aluModel(32'h002081B3, mLegal, mCode, mSrc);
        checkOutput("model_add_code", 64'(mCode), 64'h2);
        aluModel(32'h4030D313, mLegal, mCode, mSrc);
        checkOutput("model_srai_code", 64'({mLegal, mSrc, mCode}), 64'h3A);

        applyStimulus("add", 32'h002081B3, 1'b0, 0, 1'b0, nCycles);
        checkOutput("add_len", 64'(nCycles), 64'd4);
        checkOutput("add_retired", 64'(retired), 64'd1);

        applyStimulus("lw_wait3", 32'h0080A283, 1'b0, 3, 1'b0, nCycles);
        checkOutput("lw_len", 64'(nCycles), 64'd8);

        applyStimulus("beq_taken", 32'h00208463, 1'b1, 0, 1'b0, nCycles);
        applyStimulus("beq_not", 32'h00208463, 1'b0, 0, 1'b0, nCycles);
        applyStimulus("bne_taken", 32'h00209463, 1'b0, 0, 1'b0, nCycles);

        applyStimulus("sw_timeout", 32'h0050A223, 1'b0, 0, 1'b1, nCycles);
        checkOutput("timeout_len", 64'(nCycles), 64'd9);

        applyStimulus("illegal_7f", 32'h0000007F, 1'b0, 0, 1'b0, nCycles);
        checkOutput("illegal_len", 64'(nCycles), 64'd3);
        checkOutput("illegal_retired", 64'(retired), 64'd7);

        applyStimulus("sub", 32'h40208233, 1'b0, 0, 1'b0, nCycles);
        applyStimulus("srai", 32'h4030D313, 1'b0, 0, 1'b0, nCycles);
        applyStimulus("addi", 32'h00500093, 1'b1, 0, 1'b0, nCycles);
        applyStimulus("xor", 32'h0020C1B3, 1'b0, 0, 1'b0, nCycles);
        applyStimulus("sltiu_bad", 32'h0000B013, 1'b0, 0, 1'b0, nCycles);
        applyStimulus("bge_bad", 32'h0020D463, 1'b1, 0, 1'b0, nCycles);
        applyStimulus("lw_nowait", 32'h0080A283, 1'b0, 0, 1'b0, nCycles);
        checkOutput("lw_nowait_len", 64'(nCycles), 64'd5);
        applyStimulus("sw_edge_ok", 32'h0050A223, 1'b0, TIMEOUT, 1'b0, nCycles);
        applyStimulus("sw_late", 32'h0050A223, 1'b0, TIMEOUT + 1, 1'b0, nCycles);

        // Reset mid-MEM: load with no ready, abort during the second MEM cycle
        instr = 32'h0080A283; Zero = 1'b0; mem_ready = 1'b0;
        nCycles = buildTrace("lw_abort", 32'h0080A283, 1'b0, 0, 1'b1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        @(negedge clk); #2;
        expQ.delete();
        nameQ.delete();
        checkOutput("pre_abort_memread", 64'(MemRead), 64'd1);
        rst = 1'b0;
        #1;
        checkOutput("abort_outputs", 64'(actualVec()), 64'd0);
        retiredModel = 0;
        @(posedge clk); #1;
        checkOutput("abort_hold", 64'(actualVec()), 64'd0);
        rst = 1'b1;

        applyStimulus("add_after_rst", 32'h002081B3, 1'b0, 0, 1'b0, nCycles);
        checkOutput("final_retired", 64'(retired), 64'd1);

        repeat (2) @(posedge clk);
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit that sequences the single-cycle RISC-V datapath over IF/ID/EX/MEM/WB states. It decodes the fetched instruction and drives PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl and loadPC, plus data-memory strobes. It waits on a data-memory ready handshake and counts retired instructions. It sits between instruction ROM/data RAM and the datapath inside the processor top level.

## Interface
- MEM_TIMEOUT, default 16: maximum MEM-state wait cycles before a bus error aborts the access.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- instr  in  32  current instruction from ROM; stable while PC is held.
- Zero  in  1  ALU zero flag from the datapath.
- mem_ready  in  1  data memory completion; sampled only in MEM.
- PCSrc  out  1  selects the branch target for the next PC.
- ALUSrc  out  1  1 selects the immediate operand.
- RegWrite  out  1  register-file write enable.
- MemToReg  out  1  1 selects dReadData for write-back.
- ALUCtrl  out  4  ALU operation code.
- loadPC  out  1  PC update enable; one cycle per instruction.
- MemRead, MemWrite  out  1  data-memory strobes.
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode or funct.
- bus_error  out  1  one-cycle pulse on a MEM timeout.
- retired  out  32  count of instructions completed with loadPC.

## Operation
- States: IF, ID, EX, MEM, WB. Reset state is IF.
- IF→ID always; ID→EX for legal opcodes.
- ID→WB with illegal_instr=1 when the opcode is not one of: R 0110011, I 0010011, load 0000011, store 0100011, branch 1100011 (funct3 000 beq or 001 bne only). No write and no memory access occur.
- EX→MEM for load/store; EX→WB for all other classes.
- MEM→WB when mem_ready=1.
- MEM→WB with bus_error=1 after MEM_TIMEOUT cycles without mem_ready. RegWrite is suppressed in that WB.
- WB→IF always; loadPC=1 in WB; retired increments in every WB, including aborted ones.
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SRL 1000, SLL 1001, SRA 1010, XOR 1101.
- R-type decode comes from funct3 plus funct7[5]. I-type ignores funct7 except for SRAI/SRLI.
- Load and store use ADD; branch uses SUB.
- ALUSrc=1 for I-type, load and store.
- ALUCtrl and ALUSrc are driven from EX through WB and are 0 in IF/ID.
- MemRead (load) or MemWrite (store) is held for every MEM cycle.
- Zero is latched at the end of EX into zero_q. In WB, PCSrc = beq ? zero_q : bne ? !zero_q : 0.
- RegWrite=1 only in WB, for R, I and load, with no error. MemToReg=1 in WB for load.
- Other outputs are 0 in states where they are not listed.

## Timing
- Reset (rst=0, asynchronous): state=IF, zero_q=0, timeout counter=0, retired=0, all control outputs 0, pulses 0.
- Reset asserted mid-instruction aborts immediately; no write or loadPC occurs.
- Latency:
  - R/I/branch: 4 cycles.
  - Load/store: 5 + wait cycles.
  - Timeout: 4 + MEM_TIMEOUT + 1 cycles.
- Outputs are Moore: a function of state, instr and registered flags only. There is no combinational path from Zero or mem_ready to the outputs.
- mem_ready=1 on the first MEM cycle gives zero wait states.
- mem_ready arriving in the same cycle the counter reaches MEM_TIMEOUT counts as success; no bus_error.
- The timeout counter clears on MEM entry.
- retired wraps 0xFFFFFFFF→0.

## Structure
- Package ctrl_pkg holds the state enum, opcode constants, funct3 branch codes and ALU operation codes. The datapath's ALU shares these codes.
- One sub-module, alu_decoder: combinational opcode/funct3/funct7 → ALUCtrl and a legal flag.
- The FSM, timeout counter and retired counter live in multicycle_ctrl.

## Test plan
- add x3,x1,x2 (0x002081B3): IF,ID,EX,WB; ALUCtrl=0010; RegWrite=1 and loadPC=1 in cycle 4 only; retired=1.
- lw x5,8(x1) with mem_ready low for 3 MEM cycles: MemRead held for 4 cycles; MemToReg=1 and RegWrite=1 in WB; total 8 cycles.
- beq with Zero=1, then with Zero=0: PCSrc=1 in WB for the first and 0 for the second; loadPC=1 in both.
- sw with mem_ready never asserted and MEM_TIMEOUT=4: bus_error pulse after 4 MEM cycles; no RegWrite; state returns to IF.
- Opcode 0x7F: illegal_instr pulse; no write; WB→IF; retired increments.
- rst=0 asserted asynchronously mid-MEM: all outputs 0 immediately; state=IF; retired=0.
